girl_anim_ctrl: RTL and testbench
=================================

GIRL_ANIM_CTRL -- requirements
Module: girl_anim_ctrl

Interface
REQ-001 SHALL have parameter ANIM_DIV, default 6: frame ticks per animation-frame toggle (legal 1..15).
REQ-002 SHALL have parameter IDLE_HOLD, default 2: consecutive no-direction ticks before RUN returns to IDLE (legal 1..7).
REQ-003 SHALL have port Clk  input  1  system clock; the single clock, all state on its rising edge.
REQ-004 SHALL have port Reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port frame_clk  input  1  vertical-sync frame clock, asynchronous to Clk.
REQ-006 SHALL have port key_left  input  1  left key held.
REQ-007 SHALL have port key_right  input  1  right key held.
REQ-008 SHALL have port key_up  input  1  jump key held.
REQ-009 SHALL have port on_ground  input  1  character standing on platform.
REQ-010 SHALL have port girl_status  output  4  sprite select to color mapper: 0000 IDLE, 0001 RUN_R, 0010 RUN_L, 0011 JUMP.
REQ-011 SHALL have port anim_frame  output  1  alternating sprite phase within RUN states.
REQ-012 SHALL have port facing_left  output  1  last valid horizontal direction was left.
REQ-013 SHALL have port frame_tick  output  1  one-Clk pulse per frame_clk rising edge.

Function
REQ-014 frame_clk SHALL pass a 2-flop synchronizer; frame_tick SHALL pulse for exactly one Clk cycle, 3 Clk cycles after the rising edge is first sampled.
REQ-015 All state and outputs SHALL update only in frame_tick cycles, except Reset; registered outputs change 1 Clk after the tick cycle.
REQ-016 Direction dir = R if key_right&!key_left, L if key_left&!key_right, NONE otherwise (both pressed = NONE).
REQ-017 IDLE: dir R -> RUN_R, dir L -> RUN_L, NONE -> stay.
REQ-018 RUN_R/RUN_L: opposite dir -> other RUN immediately; same dir -> stay, clear idle counter; NONE -> increment idle counter; reaching IDLE_HOLD -> IDLE.
REQ-019 facing_left SHALL be set on dir L, cleared on dir R, held on NONE, in every state.
REQ-020 Animation counter SHALL count ticks 0..ANIM_DIV-1 while in a RUN state, toggle anim_frame at wrap, and clear counter and anim_frame on any state change.
REQ-021 anim_frame SHALL be 0 in IDLE and JUMP.
REQ-022 Counters SHALL saturate/wrap only as specified; no counter exceeds its parameter bound.

Reset
REQ-023 Reset SHALL force, on the next Clk edge: girl_status 0000, anim_frame 0, facing_left 0, frame_tick 0, all counters 0, synchronizer flops 0.
REQ-024 Reset asserted mid-RUN or mid-JUMP SHALL abandon the state without completing pending transitions; Reset dominates a coincident tick.
REQ-025 The first frame_clk edge after reset release SHALL be detected normally (no spurious tick if frame_clk is already high at release).

Configuration
REQ-026 Macro GIRL_ANIM_JUMP_EN SHALL compile in JUMP state; without it key_up/on_ground SHALL be ignored and girl_status never 0011.
REQ-027 With GIRL_ANIM_JUMP_EN: from IDLE/RUN, tick with key_up&on_ground -> JUMP (precedence over direction rules).
REQ-028 With GIRL_ANIM_JUMP_EN: JUMP lasts at least 2 ticks; first tick thereafter with on_ground exits to RUN per dir, or IDLE if NONE.

Structure
REQ-029 Package girl_anim_pkg SHALL hold the state enum (4-bit encodings of REQ-010) and the minimum-jump constant (2).
REQ-030 Synchronizer and edge detector SHALL be sub-module frame_tick_det (Clk, Reset, frame_clk -> frame_tick).

Verification
REQ-031 Reset, then key_right=1 across 1 tick -> girl_status 0001, facing_left 0, anim_frame 0.
REQ-032 key_right held 12 ticks, ANIM_DIV=6 -> anim_frame toggles after tick 6 and tick 12 of RUN_R.
REQ-033 In RUN_R, release keys, IDLE_HOLD=2 -> 0001 after first tick, 0000 after second; re-press before second tick -> stays 0001.
REQ-034 key_left and key_right both 1 from IDLE for 5 ticks -> girl_status stays 0000, facing_left unchanged.
REQ-035 JUMP_EN build: key_up=1, on_ground=1 in RUN_L -> 0011; on_ground=0 for 3 ticks, then 1 with key_left -> 0010.
REQ-036 Reset asserted during RUN_L with anim_frame 1 -> next Clk all outputs 0; frame_clk toggling with no keys -> frame_tick pulses once per edge, status 0000.

Source files
------------

// File: rtl/girl_anim_pkg.sv
// Shared types and constants for the girl sprite animation controller.
// Build option: define GIRL_ANIM_JUMP_EN to include the JUMP state.
package girl_anim_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0000,
        ST_RUN_R = 4'b0001,
        ST_RUN_L = 4'b0010,
        ST_JUMP  = 4'b0011
    } state_e;

    typedef enum logic [1:0] {
        DIR_NONE = 2'd0,
        DIR_R    = 2'd1,
        DIR_L    = 2'd2
    } dir_e;

    localparam int unsigned MIN_JUMP = 2;

`ifdef GIRL_ANIM_JUMP_EN
    localparam bit JUMP_EN = 1'b1;
`else
    localparam bit JUMP_EN = 1'b0;
`endif

    // Both keys held cancel out to no direction.
    function automatic dir_e decode_dir(input logic l, input logic r);
        dir_e d;
        d = DIR_NONE;
        unique case (1'b1)
            (r & ~l): d = DIR_R;
            (l & ~r): d = DIR_L;
            default:  d = DIR_NONE;
        endcase
        return d;
    endfunction

    function automatic state_e dir2state(input dir_e d);
        state_e s;
        s = ST_IDLE;
        unique case (d)
            DIR_R:   s = ST_RUN_R;
            DIR_L:   s = ST_RUN_L;
            default: s = ST_IDLE;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/girl_anim_if.sv
// Key inputs and sprite outputs between the controller shell and its FSM.
interface girl_anim_if;

    logic       key_left;
    logic       key_right;
    logic       key_up;
    logic       on_ground;
    logic [3:0] girl_status;
    logic       anim_frame;
    logic       facing_left;

    modport master (
        output key_left, key_right, key_up, on_ground,
        input  girl_status, anim_frame, facing_left
    );

    modport slave (
        input  key_left, key_right, key_up, on_ground,
        output girl_status, anim_frame, facing_left
    );

endinterface

// File: rtl/frame_tick_det.sv
// Two-flop synchronizer and rising-edge detector for the vsync frame clock.
// Edges are ignored until frame_clk has been seen low after reset.
module frame_tick_det (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_prev;
    logic       r_armed;
    logic       r_tick;
    logic [1:0] r_warm;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_armed <= 1'b0;
            r_tick  <= 1'b0;
            r_warm  <= 2'd0;
        end else begin
            r_sync1 <= frame_clk;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            if (r_warm != 2'd2)
                r_warm <= r_warm + 2'd1;
            // r_sync2 only reflects a real sample once r_warm reaches 2.
            if (r_warm == 2'd2 && !r_sync2)
                r_armed <= 1'b1;
            r_tick <= r_armed & r_sync2 & ~r_prev;
        end
    end

    assign frame_tick = r_tick;

endmodule

// File: rtl/girl_anim_ctrl_fsm.sv
// Sprite state machine: direction/jump decisions, idle hold and run animation.
module girl_anim_ctrl_fsm
    import girl_anim_pkg::*;
#(
    parameter int ANIM_DIV  = 6,
    parameter int IDLE_HOLD = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_tick,
    girl_anim_if.slave    bus
);

    localparam logic [3:0] ANIM_LAST = 4'(ANIM_DIV - 1);
    localparam logic [2:0] HOLD      = 3'(IDLE_HOLD);
    localparam logic [1:0] JUMP_LAST = 2'(MIN_JUMP - 1);

    state_e     r_state;
    logic [2:0] r_idle_cnt;
    logic [3:0] r_anim_cnt;
    logic [1:0] r_jump_cnt;
    logic       r_anim_frame;
    logic       r_facing_left;

    state_e     w_state_nxt;
    dir_e       w_dir;
    logic [2:0] w_idle_inc;
    logic [2:0] w_idle_nxt;
    logic [3:0] w_anim_nxt;
    logic [1:0] w_jump_nxt;
    logic       w_frame_nxt;
    logic       w_face_nxt;
    logic       w_jump_go;
    logic       w_is_run;

    always_comb begin
        w_dir       = decode_dir(bus.key_left, bus.key_right);
        w_state_nxt = r_state;
        w_idle_inc  = r_idle_cnt + 3'd1;
        w_idle_nxt  = r_idle_cnt;
        w_jump_nxt  = r_jump_cnt;
        w_anim_nxt  = 4'd0;
        w_frame_nxt = 1'b0;
        w_face_nxt  = r_facing_left;
        w_is_run    = (r_state == ST_RUN_R) || (r_state == ST_RUN_L);
        w_jump_go   = JUMP_EN & bus.key_up & bus.on_ground
                    & (r_state != ST_JUMP);

        unique case (w_dir)
            DIR_L:   w_face_nxt = 1'b1;
            DIR_R:   w_face_nxt = 1'b0;
            default: w_face_nxt = r_facing_left;
        endcase

        if (w_jump_go) begin
            w_state_nxt = ST_JUMP;
        end else begin
            unique case (r_state)
                ST_IDLE: w_state_nxt = dir2state(w_dir);
                ST_RUN_R, ST_RUN_L: begin
                    if (w_dir != DIR_NONE) begin
                        w_state_nxt = dir2state(w_dir);
                        w_idle_nxt  = 3'd0;
                    end else if (w_idle_inc == HOLD) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_idle_nxt = w_idle_inc;
                    end
                end
                ST_JUMP: begin
                    if (r_jump_cnt == JUMP_LAST && bus.on_ground)
                        w_state_nxt = dir2state(w_dir);
                    else if (r_jump_cnt != JUMP_LAST)
                        w_jump_nxt = r_jump_cnt + 2'd1;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end

        if (w_state_nxt != r_state) begin
            w_idle_nxt  = 3'd0;
            w_jump_nxt  = 2'd0;
        end else if (w_is_run) begin
            if (r_anim_cnt == ANIM_LAST) begin
                w_anim_nxt  = 4'd0;
                w_frame_nxt = ~r_anim_frame;
            end else begin
                w_anim_nxt  = r_anim_cnt + 4'd1;
                w_frame_nxt = r_anim_frame;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= ST_IDLE;
            r_idle_cnt    <= 3'd0;
            r_anim_cnt    <= 4'd0;
            r_jump_cnt    <= 2'd0;
            r_anim_frame  <= 1'b0;
            r_facing_left <= 1'b0;
        end else if (i_tick) begin
            r_state       <= w_state_nxt;
            r_idle_cnt    <= w_idle_nxt;
            r_anim_cnt    <= w_anim_nxt;
            r_jump_cnt    <= w_jump_nxt;
            r_anim_frame  <= w_frame_nxt;
            r_facing_left <= w_face_nxt;
        end
    end

    assign bus.girl_status = r_state;
    assign bus.anim_frame  = r_anim_frame;
    assign bus.facing_left = r_facing_left;

endmodule

// File: rtl/girl_anim_ctrl.sv
// Girl sprite animation controller top: frame tick detection plus sprite FSM.
// Build option: define GIRL_ANIM_JUMP_EN to include the JUMP state.
module girl_anim_ctrl #(
    parameter int ANIM_DIV  = 6,
    parameter int IDLE_HOLD = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       key_left,
    input  logic       key_right,
    input  logic       key_up,
    input  logic       on_ground,
    output logic [3:0] girl_status,
    output logic       anim_frame,
    output logic       facing_left,
    output logic       frame_tick
);

    logic w_tick;

    girl_anim_if u_bus ();

    frame_tick_det u_det (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (w_tick)
    );

    assign u_bus.key_left  = key_left;
    assign u_bus.key_right = key_right;
    assign u_bus.key_up    = key_up;
    assign u_bus.on_ground = on_ground;

    girl_anim_ctrl_fsm #(
        .ANIM_DIV  (ANIM_DIV),
        .IDLE_HOLD (IDLE_HOLD)
    ) u_fsm (
        .i_clk  (Clk),
        .i_rst  (Reset),
        .i_tick (w_tick),
        .bus    (u_bus.slave)
    );

    assign girl_status = u_bus.girl_status;
    assign anim_frame  = u_bus.anim_frame;
    assign facing_left = u_bus.facing_left;
    assign frame_tick  = w_tick;

endmodule

// File: tb/tb_girl_anim_ctrl.sv
// Self-checking bench for girl_anim_ctrl: vector table, directed corners,
// and random keys against a tick-level behavioural model.
module tb_girl_anim_ctrl;

    localparam int ANIM_DIV  = 6;
    localparam int IDLE_HOLD = 2;
`ifdef GIRL_ANIM_JUMP_EN
    localparam bit JEN = 1'b1;
`else
    localparam bit JEN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fclk = 1'b0;
    logic ftick;

    always #5 clk = ~clk;

    girl_anim_if u_if ();

    girl_anim_ctrl #(
        .ANIM_DIV  (ANIM_DIV),
        .IDLE_HOLD (IDLE_HOLD)
    ) dut (
        .Clk         (clk),
        .Reset       (rst),
        .frame_clk   (fclk),
        .key_left    (u_if.key_left),
        .key_right   (u_if.key_right),
        .key_up      (u_if.key_up),
        .on_ground   (u_if.on_ground),
        .girl_status (u_if.girl_status),
        .anim_frame  (u_if.anim_frame),
        .facing_left (u_if.facing_left),
        .frame_tick  (ftick)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic keys(input bit l, input bit r, input bit u, input bit g);
        u_if.key_left  = l;
        u_if.key_right = r;
        u_if.key_up    = u;
        u_if.on_ground = g;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        fclk = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    // One frame_clk pulse; returns with outputs settled after the tick.
    task automatic tick_once(input string nm);
        int n;
        n = 0;
        @(negedge clk);
        fclk = 1'b1;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (ftick !== 1'b1 && n < 8);
        chk({nm, "_lat"}, n, 3);
        @(posedge clk);
        #1;
        chk({nm, "_width"}, {31'd0, ftick}, 0);
        @(negedge clk);
        fclk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string nm, input int st, input int face,
                           input int anim);
        chk({nm, "_status"}, {28'd0, u_if.girl_status}, st);
        chk({nm, "_facing"}, {31'd0, u_if.facing_left}, face);
        chk({nm, "_anim"},   {31'd0, u_if.anim_frame}, anim);
    endtask

    // Model: status 0..3, ticks spent in the current RUN, no-dir streak,
    // ticks spent in JUMP.
    int m_st, m_face, m_run, m_streak, m_jt;

    task automatic model_reset();
        m_st = 0; m_face = 0; m_run = 0; m_streak = 0; m_jt = 0;
    endtask

    task automatic model_step(input bit l, input bit r, input bit u,
                              input bit g);
        int dir, nxt;
        dir = (r && !l) ? 1 : (l && !r) ? 2 : 0;
        if (dir == 1) m_face = 0;
        if (dir == 2) m_face = 1;
        nxt = m_st;
        if (JEN && u && g && m_st != 3) begin
            nxt = 3;
        end else if (m_st == 0) begin
            nxt = dir;
        end else if (m_st == 3) begin
            m_jt++;
            if (m_jt >= 2 && g) nxt = dir;
        end else if (dir != 0) begin
            nxt = dir;
            m_streak = 0;
        end else begin
            m_streak++;
            if (m_streak >= IDLE_HOLD) nxt = 0;
        end
        if (nxt != m_st) begin
            m_run = 0; m_streak = 0; m_jt = 0;
        end else if (m_st == 1 || m_st == 2) begin
            m_run++;
        end
        m_st = nxt;
    endtask

    function automatic int model_anim();
        if (m_st == 1 || m_st == 2) return (m_run / ANIM_DIV) % 2;
        return 0;
    endfunction

    typedef struct {
        bit l;
        bit r;
        int st;
        int face;
        int anim;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit l, input bit r, input int st,
                       input int face, input int anim, input int rep);
        vec_t v;
        v.l = l; v.r = r; v.st = st; v.face = face; v.anim = anim;
        for (int i = 0; i < rep; i++) tbl.push_back(v);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        bit l, r, u, g;
        keys(0, 0, 0, 0);

        // Table from reset: run, animation, idle hold, both keys, reversal.
        add(0, 1, 1, 0, 0, 6);
        add(0, 1, 1, 0, 1, 6);
        add(0, 1, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1);
        add(0, 1, 1, 0, 0, 1);
        add(0, 0, 1, 0, 0, 1);
        add(0, 0, 0, 0, 0, 1);
        add(1, 0, 2, 1, 0, 1);
        add(1, 1, 2, 1, 0, 1);
        add(1, 1, 0, 1, 0, 6);
        add(0, 1, 1, 0, 0, 1);
        add(1, 0, 2, 1, 0, 1);
        add(0, 1, 1, 0, 0, 1);

        do_reset();
        chk_out("reset", 0, 0, 0);
        chk("reset_tick", {31'd0, ftick}, 0);
        foreach (tbl[i]) begin
            keys(tbl[i].l, tbl[i].r, 0, 0);
            tick_once("tbl");
            chk_out($sformatf("tbl%0d", i), tbl[i].st, tbl[i].face,
                    tbl[i].anim);
        end

        // Reset mid RUN_L with anim_frame high, coincident with a tick.
        do_reset();
        keys(1, 0, 0, 0);
        repeat (7) tick_once("runl");
        chk_out("runl_pre", 2, 1, 1);
        @(negedge clk);
        fclk = 1'b1;
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (ftick !== 1'b1 && cnt < 8);
        chk("coinc_tick_seen", {31'd0, ftick}, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk_out("rst_dom", 0, 0, 0);
        chk("rst_dom_tick", {31'd0, ftick}, 0);
        keys(0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (ftick) cnt++;
        end
        chk("no_spurious_tick", cnt, 0);
        @(negedge clk);
        fclk = 1'b0;
        repeat (4) @(posedge clk);
        keys(0, 1, 0, 0);
        tick_once("first_edge");
        chk_out("first_edge", 1, 0, 0);

        // Free-running frame_clk with no keys: one pulse per rising edge.
        do_reset();
        keys(0, 0, 0, 0);
        cnt = 0;
        for (int c = 0; c < 52; c++) begin
            @(negedge clk);
            fclk = (c < 48) && ((c / 6) % 2 == 1);
            @(posedge clk);
            #1;
            if (ftick) cnt++;
        end
        chk("pulse_count", cnt, 4);
        chk_out("toggle_idle", 0, 0, 0);

        // Jump key handling.
        do_reset();
        keys(1, 0, 0, 0);
        tick_once("j");
        chk_out("j_runl", 2, 1, 0);
        keys(1, 0, 1, 1);
        tick_once("j");
`ifdef GIRL_ANIM_JUMP_EN
        chk_out("j_enter", 3, 1, 0);
        keys(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick_once("j");
            chk_out($sformatf("j_air%0d", i), 3, 1, 0);
        end
        keys(1, 0, 0, 1);
        tick_once("j");
        chk_out("j_land", 2, 1, 0);
        keys(0, 0, 1, 1);
        tick_once("j");
        chk_out("j_idle_enter", 3, 1, 0);
        keys(0, 1, 0, 1);
        tick_once("j");
        chk_out("j_min1", 3, 0, 0);
        keys(0, 0, 0, 1);
        tick_once("j");
        chk_out("j_min2", 0, 0, 0);
`else
        chk_out("j_ignored", 2, 1, 0);
        keys(0, 0, 1, 1);
        tick_once("j");
        tick_once("j");
        chk_out("j_ignored_idle", 0, 1, 0);
`endif

        // Random keys against the model.
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            l = ($urandom % 3) == 0;
            r = ($urandom % 3) == 0;
            u = ($urandom % 5) == 0;
            g = ($urandom % 2) == 0;
            keys(l, r, u, g);
            model_step(l, r, u, g);
            tick_once("rnd");
            chk_out($sformatf("rnd%0d", i), m_st, m_face, model_anim());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
